// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The FSM state encoding is fixed so it stays stable across tools and waveform viewers.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between a controller (master) and the serial subtractor (slave).
// SERIAL_SUB_BIN_EN adds the borrow-in input used when chaining wider subtractions.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_BIN_EN
    logic             bin;

    modport master (output start, a, b, bin, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, bin, output busy, done, diff, borrow_out);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_fs_bit.sv
// Combinational full-subtractor cell: d = a ^ b ^ bin, with the matching borrow out.
// Uses the same two-XOR structure as the adder bit cell.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic axb;

    xor u_xor_ab  (axb, a, b);
    xor u_xor_bin (d, axb, bin);

    // Borrow when a<b at this bit, or when a==b and a borrow is still pending.
    assign bout = (~a & b) | (~axb & bin);
endmodule : fs_bit

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a one-bit borrow register.
// Defining SERIAL_SUB_BIN_EN adds bus.bin as the initial borrow (computes a - b - bin).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bout;
    logic             init_borrow;
    logic [WIDTH-1:0] res_shifted;

`ifdef SERIAL_SUB_BIN_EN
    assign init_borrow = bus.bin;
`else
    assign init_borrow = 1'b0;
`endif

    fs_bit u_fs_bit (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New bits enter from the MSB so after WIDTH shifts bit 0 lands at index 0.
    assign res_shifted = {cell_d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_shifted;
                br_d   = cell_bout;
                if (cnt_q == LAST_CNT) begin
                    diff_d   = res_shifted;
                    borrow_d = cell_bout;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = init_borrow;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, random vectors against an
// arithmetic reference, ignored start, back-to-back, and asynchronous reset mid-operation.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: plain signed arithmetic; the borrow is simply "result went negative".
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bi);
        int dv;
        logic [W:0] r;
        dv = int'(a) - int'(b) - int'(bi);
        r[W-1:0] = dv[W-1:0];
        r[W]     = (dv < 0);
        return r;
    endfunction

    // Presents a request for exactly one rising edge; returns at the falling edge after it.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
`ifdef SERIAL_SUB_BIN_EN
        bus.bin   = bi;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
`ifdef SERIAL_SUB_BIN_EN
        bus.bin   = 1'($urandom);
`endif
    endtask

    // Counts rising edges after the accepting one until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1) begin
            @(negedge clk);
            lat++;
            if (lat > 4 * W) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.borrow_out} !== 3'b000 || bus.diff !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] va [4] = '{8'h5A, 8'h10, 8'h00, 8'hFF};
        logic [W-1:0] vb [4] = '{8'h23, 8'h20, 8'h01, 8'hFF};
        logic [W-1:0] vd [4] = '{8'h37, 8'hF0, 8'hFF, 8'h00};
        logic         vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            drive_start(va[i], vb[i], 1'b0);
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_busy: busy=%b, required 1", i, bus.busy);
            end
            wait_done(lat);
            checks++;
            if (lat != W) begin
                errors++;
                $display("FAIL dir%0d_latency: %0d, required %0d", i, lat, W);
            end
            checks++;
            if (bus.diff !== vd[i] || bus.borrow_out !== vo[i] || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result: diff=%h bout=%b busy=%b, required %h %b 0",
                         i, bus.diff, bus.borrow_out, bus.busy, vd[i], vo[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.diff !== vd[i] || bus.borrow_out !== vo[i]) begin
                errors++;
                $display("FAIL dir%0d_hold: done=%b diff=%h bout=%b, required 0 %h %b",
                         i, bus.done, bus.diff, bus.borrow_out, vd[i], vo[i]);
            end
            $display("dir %0d: %h - %h -> diff=%h bout=%b lat=%0d", i, va[i], vb[i],
                     bus.diff, bus.borrow_out, lat);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, prev_diff;
        logic         bi, prev_bout;
        logic [W:0]   exp;
        int lat;
        for (int i = 0; i < 20; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
`ifdef SERIAL_SUB_BIN_EN
            bi = 1'($urandom);
`else
            bi = 1'b0;
`endif
            exp       = ref_sub(a, b, bi);
            prev_diff = bus.diff;
            prev_bout = bus.borrow_out;
            drive_start(a, b, bi);
            repeat (W / 2) @(negedge clk);
            checks++;
            if (bus.diff !== prev_diff || bus.borrow_out !== prev_bout) begin
                errors++;
                $display("FAIL rnd%0d_stable: diff=%h bout=%b, required %h %b",
                         i, bus.diff, bus.borrow_out, prev_diff, prev_bout);
            end
            wait_done(lat);
            lat += W / 2;
            checks++;
            if (lat != W || bus.diff !== exp[W-1:0] || bus.borrow_out !== exp[W]) begin
                errors++;
                $display("FAIL rnd%0d_result: diff=%h bout=%b lat=%0d, required %h %b %0d",
                         i, bus.diff, bus.borrow_out, lat, exp[W-1:0], exp[W], W);
            end
            $display("rnd %0d: %h - %h - %b -> diff=%h bout=%b", i, a, b, bi,
                     bus.diff, bus.borrow_out);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        drive_start(8'h5A, 8'h23, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        lat += 3;
        checks++;
        if (lat != W || bus.diff !== 8'h37 || bus.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: diff=%h bout=%b lat=%0d, required 37 0 %0d",
                     bus.diff, bus.borrow_out, lat, W);
        end
        // Request again during the DONE cycle.
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", bus.busy, bus.done);
        end
        wait_done(lat);
        checks++;
        if (lat != W || bus.diff !== 8'hF0 || bus.borrow_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result: diff=%h bout=%b lat=%0d, required f0 1 %0d",
                     bus.diff, bus.borrow_out, lat, W);
        end
        $display("b2b: 5a-23 then 10-20 -> diff=%h bout=%b lat=%0d", bus.diff,
                 bus.borrow_out, lat);
    endtask

    task automatic test_reset_mid_shift;
        int  lat;
        bit  saw_done;
        drive_start(8'h5A, 8'h23, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 || bus.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: busy=%b done=%b diff=%h bout=%b, required 0 0 00 0",
                     bus.busy, bus.done, bus.diff, bus.borrow_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL rst_no_done: activity after reset, required none");
        end
        drive_start(8'h5A, 8'h23, 1'b0);
        wait_done(lat);
        checks++;
        if (lat != W || bus.diff !== 8'h37 || bus.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh: diff=%h bout=%b lat=%0d, required 37 0 %0d",
                     bus.diff, bus.borrow_out, lat, W);
        end
        $display("rst mid-shift then 5a-23 -> diff=%h bout=%b", bus.diff, bus.borrow_out);
    endtask

`ifdef SERIAL_SUB_BIN_EN
    task automatic test_bin;
        int lat;
        drive_start(8'h00, 8'h00, 1'b1);
        wait_done(lat);
        checks++;
        if (lat != W || bus.diff !== 8'hFF || bus.borrow_out !== 1'b1) begin
            errors++;
            $display("FAIL bin: diff=%h bout=%b lat=%0d, required ff 1 %0d",
                     bus.diff, bus.borrow_out, lat, W);
        end
        $display("bin: 00 - 00 - 1 -> diff=%h bout=%b", bus.diff, bus.borrow_out);
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SERIAL_SUB_BIN_EN
        bus.bin   = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef SERIAL_SUB_BIN_EN
        test_bin();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule : tb_serial_subtractor
